// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode hex display driver with per-frame snapshot
// and a one-cycle anode guard slot. Optional leading-zero blanking via `SEG7_LZB_EN.
module seg7_scan_driver #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blank_i,
  output logic [7:0]            an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_data_q, snap_data_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0]   snap_blank_q, snap_blank_d;
  logic [7:0]          an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                frame_q, frame_d;

  logic                terminal;
  logic [2:0]          an_sel;
  logic [3:0]          nib [DIGITS];
  logic [DIGITS-1:0]   lz;
  logic [DIGITS-1:0]   hide;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign nib[gi] = snap_data_q[4*gi +: 4];
    end
  endgenerate

`ifdef SEG7_LZB_EN
  // A digit is a leading zero when it and every higher nibble are zero; digit 0 always shows.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_first
        assign lz[gi] = 1'b0;
      end else begin : g_upper
        assign lz[gi] = ~|snap_data_q[4*DIGITS-1:4*gi];
      end
    end
  endgenerate
`else
  assign lz = '0;
`endif

  assign hide     = snap_blank_q | lz;
  assign terminal = (cnt_q == CNT_LAST);
  assign an_sel   = 3'(idx_q);

  always_comb begin
    cnt_d        = terminal ? '0 : cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    snap_data_d  = snap_data_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;
    an_d         = 8'hFF;
    seg_d        = seg_q;
    dp_d         = dp_q;
    frame_d      = 1'b0;

    if (terminal) begin
      // Guard slot: anodes dark while segments keep their value to avoid ghosting.
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      if (idx_q == IDX_LAST) begin
        snap_data_d  = data_i;
        snap_dp_d    = dp_i;
        snap_blank_d = blank_i;
        frame_d      = 1'b1;
      end
    end else begin
      if (!hide[idx_q]) begin
        an_d[an_sel] = 1'b0;
      end
      seg_d = decode(nib[idx_q]);
      dp_d  = ~(snap_dp_q[idx_q] & ~lz[idx_q]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_data_q  <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_data_q  <= snap_data_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_q      <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIGITS=8, REFRESH_DIV=4): table-driven digit
// vectors plus hand sequences for scan order, snapshot consistency and async reset.
module tb_seg7_scan_driver;

  localparam int DIGITS = 8;
  localparam int RDIV   = 4;
  localparam int FRAME  = DIGITS * RDIV;
`ifdef SEG7_LZB_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] data_i;
  logic [7:0]  dp_i;
  logic [7:0]  blank_i;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_o;

  seg7_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .dp_i    (dp_i),
    .blank_i (blank_i),
    .an_o    (an_o),
    .seg_o   (seg_o),
    .dp_o    (dp_o),
    .frame_o (frame_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  blank;
    int          digit;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dpo;
  } vec_t;

  localparam int NVEC = 27;
  vec_t       vecs [NVEC];
  logic [6:0] dec_tab [16];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic goto_cyc(input int e);
    while (cyc < e) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int next_snap(input int c);
    return (c / FRAME + 1) * FRAME;
  endfunction

  task automatic run_vec(input int i);
    int s;
    data_i  = vecs[i].data;
    dp_i    = vecs[i].dp;
    blank_i = vecs[i].blank;
    s = next_snap(cyc);
    goto_cyc(s + RDIV * vecs[i].digit + 2);
    chk("vec_an", 32'(an_o), 32'(vecs[i].an));
    chk("vec_seg", 32'(seg_o), 32'(vecs[i].seg));
    chk("vec_dp", 32'(dp_o), 32'(vecs[i].dpo));
    $display("vec %0d data=%h dp=%h blank=%h digit=%0d an=%h seg=%b dp_o=%b",
             i, vecs[i].data, vecs[i].dp, vecs[i].blank, vecs[i].digit, an_o, seg_o, dp_o);
  endtask

  initial begin
    logic [7:0]  exp_an;
    logic [3:0]  nb;
    logic [31:0] val;
    int          s;
    int          d;
    bit          guard;

    dec_tab[0]  = 7'b0000001; dec_tab[1]  = 7'b1001111;
    dec_tab[2]  = 7'b0010010; dec_tab[3]  = 7'b0000110;
    dec_tab[4]  = 7'b1001100; dec_tab[5]  = 7'b0100100;
    dec_tab[6]  = 7'b0100000; dec_tab[7]  = 7'b0001111;
    dec_tab[8]  = 7'b0000000; dec_tab[9]  = 7'b0000100;
    dec_tab[10] = 7'b0001000; dec_tab[11] = 7'b1100000;
    dec_tab[12] = 7'b0110001; dec_tab[13] = 7'b1000010;
    dec_tab[14] = 7'b0110000; dec_tab[15] = 7'b0111000;

    vecs[0]  = '{32'h76543210, 8'h00, 8'h00, 0, 8'hFE, 7'b0000001, 1'b1};
    vecs[1]  = '{32'h76543210, 8'h00, 8'h00, 1, 8'hFD, 7'b1001111, 1'b1};
    vecs[2]  = '{32'h76543210, 8'h00, 8'h00, 2, 8'hFB, 7'b0010010, 1'b1};
    vecs[3]  = '{32'h76543210, 8'h00, 8'h00, 3, 8'hF7, 7'b0000110, 1'b1};
    vecs[4]  = '{32'h76543210, 8'h00, 8'h00, 4, 8'hEF, 7'b1001100, 1'b1};
    vecs[5]  = '{32'h76543210, 8'h00, 8'h00, 5, 8'hDF, 7'b0100100, 1'b1};
    vecs[6]  = '{32'h76543210, 8'h00, 8'h00, 6, 8'hBF, 7'b0100000, 1'b1};
    vecs[7]  = '{32'h76543210, 8'h00, 8'h00, 7, 8'h7F, 7'b0001111, 1'b1};
    vecs[8]  = '{32'hFEDCBA98, 8'h00, 8'h00, 0, 8'hFE, 7'b0000000, 1'b1};
    vecs[9]  = '{32'hFEDCBA98, 8'h00, 8'h00, 1, 8'hFD, 7'b0000100, 1'b1};
    vecs[10] = '{32'hFEDCBA98, 8'h00, 8'h00, 2, 8'hFB, 7'b0001000, 1'b1};
    vecs[11] = '{32'hFEDCBA98, 8'h00, 8'h00, 3, 8'hF7, 7'b1100000, 1'b1};
    vecs[12] = '{32'hFEDCBA98, 8'h00, 8'h00, 4, 8'hEF, 7'b0110001, 1'b1};
    vecs[13] = '{32'hFEDCBA98, 8'h00, 8'h00, 5, 8'hDF, 7'b1000010, 1'b1};
    vecs[14] = '{32'hFEDCBA98, 8'h00, 8'h00, 6, 8'hBF, 7'b0110000, 1'b1};
    vecs[15] = '{32'hFEDCBA98, 8'h00, 8'h00, 7, 8'h7F, 7'b0111000, 1'b1};
    vecs[16] = '{32'h12345678, 8'h10, 8'h0F, 0, 8'hFF, 7'b0000000, 1'b1};
    vecs[17] = '{32'h12345678, 8'h10, 8'h0F, 2, 8'hFF, 7'b0100000, 1'b1};
    vecs[18] = '{32'h12345678, 8'h10, 8'h0F, 4, 8'hEF, 7'b1001100, 1'b0};
    vecs[19] = '{32'h12345678, 8'h10, 8'h0F, 5, 8'hDF, 7'b0000110, 1'b1};
    vecs[20] = '{32'h00000305, 8'h00, 8'h00, 0, 8'hFE, 7'b0100100, 1'b1};
    vecs[21] = '{32'h00000305, 8'h00, 8'h00, 1, 8'hFD, 7'b0000001, 1'b1};
    vecs[22] = '{32'h00000305, 8'h00, 8'h00, 2, 8'hFB, 7'b0000110, 1'b1};
    vecs[23] = '{32'h00000305, 8'h00, 8'h00, 3, LZ ? 8'hFF : 8'hF7, 7'b0000001, 1'b1};
    vecs[24] = '{32'h00000305, 8'h80, 8'h00, 7, LZ ? 8'hFF : 8'h7F, 7'b0000001, LZ ? 1'b1 : 1'b0};
    vecs[25] = '{32'h00000000, 8'h00, 8'h00, 0, 8'hFE, 7'b0000001, 1'b1};
    vecs[26] = '{32'h00000000, 8'h00, 8'h00, 1, LZ ? 8'hFF : 8'hFD, 7'b0000001, 1'b1};

    // Reset state while held.
    rst_i   = 1'b1;
    data_i  = 32'h12345678;
    dp_i    = 8'h00;
    blank_i = 8'h00;
    tick();
    tick();
    chk("rst_an", 32'(an_o), 32'hFF);
    chk("rst_seg", 32'(seg_o), 32'h7F);
    chk("rst_dp", 32'(dp_o), 32'h1);
    chk("rst_frame", 32'(frame_o), 32'h0);
    rst_i = 1'b0;
    cyc   = 0;

    // Two frames: zero snapshot first, then 0x12345678; guard slots and frame pulses.
    for (int e = 1; e <= 2 * FRAME; e++) begin
      tick();
      d     = ((e - 1) / RDIV) % DIGITS;
      guard = (((e - 1) % RDIV) == RDIV - 1);
      exp_an = 8'hFF;
      if (!guard) exp_an[d] = 1'b0;
      chk("scan_an", 32'(an_o), 32'(exp_an));
      chk("scan_frame", 32'(frame_o), (e % FRAME == 0) ? 32'h1 : 32'h0);
      if (!guard) begin
        val = 32'h12345678;
        nb  = 4'((val >> (4 * d)) & 32'hF);
        chk("scan_seg", 32'(seg_o), 32'((e <= FRAME) ? dec_tab[0] : dec_tab[nb]));
        chk("scan_dp", 32'(dp_o), 32'h1);
      end
    end

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Snapshot consistency: data change mid-frame must not tear the current frame.
    data_i  = 32'hAAAAAAAA;
    dp_i    = 8'h00;
    blank_i = 8'h00;
    s = next_snap(cyc);
    goto_cyc(s + RDIV * 3 + 2);
    chk("snap_d3", 32'(seg_o), 32'(7'b0001000));
    data_i = 32'hCCCCCCCC;
    for (int k = 4; k < DIGITS; k++) begin
      goto_cyc(s + RDIV * k + 2);
      chk("snap_old", 32'(seg_o), 32'(7'b0001000));
    end
    goto_cyc(s + FRAME - 1);
    chk("frame_pre", 32'(frame_o), 32'h0);
    goto_cyc(s + FRAME);
    chk("frame_hi", 32'(frame_o), 32'h1);
    goto_cyc(s + FRAME + 1);
    chk("frame_post", 32'(frame_o), 32'h0);
    for (int k = 0; k < DIGITS; k++) begin
      goto_cyc(s + FRAME + RDIV * k + 2);
      chk("snap_new", 32'(seg_o), 32'(7'b0110001));
    end

    // Asynchronous reset asserted between clock edges, mid-scan.
    tick();
    #3;
    rst_i = 1'b1;
    #1;
    chk("arst_an", 32'(an_o), 32'hFF);
    chk("arst_seg", 32'(seg_o), 32'h7F);
    chk("arst_dp", 32'(dp_o), 32'h1);
    chk("arst_frame", 32'(frame_o), 32'h0);
    tick();
    chk("arst_hold_an", 32'(an_o), 32'hFF);
    rst_i = 1'b0;
    cyc   = 0;
    tick();
    chk("rel_an1", 32'(an_o), 32'hFE);
    chk("rel_seg1", 32'(seg_o), 32'(7'b0000001));
    tick();
    tick();
    chk("rel_an3", 32'(an_o), 32'hFE);
    tick();
    chk("rel_guard", 32'(an_o), 32'hFF);
    tick();
    chk("rel_an5", 32'(an_o), 32'hFD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed seven-segment display driver. It consumes the 32-bit processor output word and drives the board's 8-digit common-anode display. Each digit shows its nibble as a full hex glyph (0-F). A frame-consistent snapshot of the data prevents tearing, and a one-cycle anode guard between digits suppresses ghosting. It sits directly downstream of the processor's out_o in the board top level and replaces the inline scan logic there.

Parameters:
DIGITS, 8, number of digits scanned (1..8); data_i width is 4*DIGITS.
REFRESH_DIV, 1000, clock cycles per digit slot (>=2).

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset
data_i  input  4*DIGITS  value to display; nibble k drives digit k (digit 0 = bits [3:0], rightmost)
dp_i  input  DIGITS  decimal point request per digit (1 = lit)
blank_i  input  DIGITS  per-digit force-blank mask (1 = digit dark)
an_o  output  8  anode enables, active low; bits above DIGITS-1 are tied 1
seg_o  output  7  {CA,CB,CC,CD,CE,CF,CG}, active low
dp_o  output  1  decimal point, active low
frame_o  output  1  one-cycle pulse when a new snapshot is taken

Interface: one clock; reset is asynchronous and active-high (clk_i, rst_i).

Behaviour:
- Reset (async, immediate): an_o=8'hFF, seg_o=7'h7F, dp_o=1, frame_o=0, prescaler cnt=0, digit index idx=0, snapshot registers (data, dp, blank) all 0.
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps to 0.
- Terminal cycle (cnt==REFRESH_DIV-1):
  - idx advances, wrapping DIGITS-1 -> 0.
  - an_o is registered to 8'hFF (guard slot); seg_o and dp_o hold their values.
- Any other cycle: an_o is registered to all-ones except bit idx=0, unless snap_blank[idx]=1 (then all-ones). seg_o is registered to decode(snap_data nibble idx); dp_o is registered to ~snap_dp[idx].
- Latency: outputs are registered and reflect idx one cycle after it changes. Each digit is lit REFRESH_DIV-1 cycles per slot, with 1 guard cycle.
- Snapshot: on the terminal cycle with idx==DIGITS-1, snap_data<=data_i, snap_dp<=dp_i, snap_blank<=blank_i, and frame_o<=1 for exactly one cycle. data_i, dp_i and blank_i changes at any other time do not affect the display until the next snapshot. The first frame after reset therefore shows all "0".
- Decode table (CA..CG, active low):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- DIGITS=1: idx stays 0; a snapshot is taken every REFRESH_DIV cycles.
- Reset asserted mid-scan: all state returns to reset values asynchronously. After release, scanning restarts at digit 0 with cnt=0.

Optional Feature:
Macro SEG7_LZB_EN (leading-zero blanking).
- With it defined: in addition to blank_i, any digit k>0 whose snapshot nibble and all higher nibbles are 0 is blanked (anode off, dp suppressed). Digit 0 is never blanked by this rule; a value of 0 shows a single "0".
- Without it: all digits display, including leading zeros; only blank_i blanks.

Test Plan:
- Reset: hold rst_i mid-scan -> an_o=FF, seg_o=7F, dp_o=1, frame_o=0 immediately, asynchronous to clk_i; after release the first lit anode is an_o=FE.
- Scan order, REFRESH_DIV=4, data_i=0x12345678 held:
  - Second frame shows digit 0 seg=0000000 ("8"), then digit 1 seg=0001111 ("7"), up to digit 7 seg=1001111 ("1").
  - Anode sequence is FE, FD, FB ... 7F, each lit 3 cycles with one FF guard cycle between.
- Snapshot consistency: change data_i from 0xAAAAAAAA to 0xCCCCCCCC while idx=3 -> digits 4..7 still show "A" (0001000) in the current frame. "C" (0110001) appears only after the next frame_o pulse, which is exactly 1 cycle wide and spaced 8*REFRESH_DIV cycles apart.
- Masks: blank_i=8'h0F, dp_i=8'h10 -> an_o stays FF during digit 0-3 slots; dp_o=0 only during digit 4's slot.
- Hex coverage: cycle data_i through nibbles 0..F -> seg_o matches every decode table entry, including b=1100000 and d=1000010.
- SEG7_LZB_EN:
  - data_i=0x00000305 -> only digits 0..2 lit, showing "5", "0", "3".
  - data_i=0 -> only digit 0 lit, seg=0000001.
  - Without the macro, the same 0x00000305 stimulus lights all 8 digits.
